braille_rom_sequencer: RTL
==========================

# braille_rom_sequencer

Parametrised ROM walk controller for the Braille trainer. Steps a ROM address from `FIRST_ADDR` to `LAST_ADDR` and waits a configurable read latency at each address. Captures each ROM word into a held output register and waits for a consumer acknowledge before advancing. Supports one-shot and looping passes and restart after completion. Sits between the character/pattern ROM and the cell-driver/display logic.

## Interface
- `ADDR_W`, 3: ROM address width.
- `DATA_W`, 16: ROM word width.
- `FIRST_ADDR`, 0: first address of a pass.
- `LAST_ADDR`, 5: last address of a pass; elaboration error unless `FIRST_ADDR <= LAST_ADDR <= 2^ADDR_W-1`.
- `READ_LAT`, 2: ROM cycles from address change to valid `q`; elaboration error if < 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a pass; accepted only in IDLE or DONE.
- `loop`  in  1  sampled at the last address's acknowledge: 1 = wrap to `FIRST_ADDR`, 0 = finish.
- `advance`  in  1  consumer acknowledge of `data_out`.
- `q`  in  DATA_W  ROM read data.
- `address`  out  ADDR_W  ROM address (registered).
- `data_out`  out  DATA_W  captured ROM word.
- `data_valid`  out  1  `data_out` holds an unacknowledged word.
- `busy`  out  1  high in WAIT and PRESENT.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, WAIT, PRESENT, DONE.
- Reset (async, `rst`=0): state IDLE, `address`=`FIRST_ADDR`, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0, wait counter=0.
- IDLE/DONE with `start`=1: `address`<=`FIRST_ADDR`, counter<=0, `done`<=0, go to WAIT. `advance` is ignored in these states.
- WAIT: counter increments each cycle. When counter==`READ_LAT`: `data_out`<=`q`, `data_valid`<=1, go to PRESENT. `start` and `advance` are ignored.
- PRESENT: hold `data_out` and `data_valid`. On `advance`=1, `data_valid`<=0, then:
  - If `address` != `LAST_ADDR`: `address`<=`address`+1, counter<=0, go to WAIT.
  - If `address` == `LAST_ADDR` and `loop`=1: `address`<=`FIRST_ADDR`, counter<=0, go to WAIT.
  - If `address` == `LAST_ADDR` and `loop`=0: `done`<=1, go to DONE; `address` holds `LAST_ADDR`.
- `advance` and `start` together in PRESENT: `advance` is taken, `start` is ignored.
- `data_out` retains its last value in DONE and IDLE; it changes only on capture or reset.
- Counter width is `$clog2(READ_LAT+1)`. Address increment never wraps past `LAST_ADDR`; the only wrap is the explicit loop.

## Timing
- Address update at edge E0 → capture at edge E(`READ_LAT`+1); `data_valid` rises `READ_LAT`+1 cycles after `address` changes (3 cycles at the default).
- `start` sampled at edge S → `busy`=1 and `address`=`FIRST_ADDR` after S → first `data_valid` after edge S+`READ_LAT`+1.
- `advance` sampled at edge A → `data_valid`=0 after A. The next word is valid `READ_LAT`+1 edges later, so the minimum per-word period is `READ_LAT`+2 cycles.
- `done` rises one edge after the final `advance` and stays high until `start` or reset.
- Reset asserted mid-pass clears all outputs immediately; no partial word is presented after release.

## Structure
- Package `braille_seq_pkg` holds:
  - the state enum (IDLE, WAIT, PRESENT, DONE);
  - the default `ADDR_W`, `DATA_W` and `READ_LAT` constants.
- One sub-module, `seq_wait_timer`: a parametrised up-counter with clear, enable and a terminal flag (`count == READ_LAT`), using the same `clk`/`rst`.
- The top level holds the FSM, the address register and the capture register.

## Test plan
- Defaults, `start` pulse, ROM model with latency 2 and `q`=0xA000+addr, `advance` one cycle after each valid, `loop`=0 → words 0xA000..0xA005 in order; each `data_valid` 3 cycles after its address change; `done`=1 after the sixth ack; `address`=5.
- Consumer stalls `advance` 10 cycles on word 2 → `data_out`=0xA002 and `data_valid`=1 held throughout; `address` stays 2.
- `loop`=1 at the last ack → `address` returns to 0; 0xA000 is presented again; `done` stays 0.
- `start` and `advance` pulsed in WAIT, and `start` in PRESENT alongside `advance` → start ignored, sequence unchanged; in DONE, `advance` ignored and `start` restarts at address 0.
- `rst` low mid-WAIT at address 3 → `address`=0, `data_valid`=0, `busy`=0 asynchronously; after release, IDLE until `start`.
- Re-parametrise `ADDR_W`=5, `FIRST_ADDR`=4, `LAST_ADDR`=20, `READ_LAT`=1 → 17 words delivered, each valid 2 cycles after its address change.

Source files
------------

// File: rtl/braille_rom_sequencer_pkg.sv
// braille_seq_pkg
// Shared definitions for the Braille trainer ROM walk controller:
//   - seq_state_e : controller state encoding (IDLE, WAIT, PRESENT, DONE)
//   - DEF_*       : default address width, ROM word width and ROM read latency
package braille_seq_pkg;

    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_READ_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer
// Up-counter that measures the ROM read latency at each address.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-low reset (count -> 0)
//   clr_i  in  synchronous clear to 0 (has priority over enable)
//   en_i   in  count enable; the count saturates at READ_LAT
//   term_o out count == READ_LAT
module seq_wait_timer #(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(READ_LAT);

    logic [CNT_W-1:0] count_q;

    // Holding at the terminal value keeps the counter inside its
    // $clog2(READ_LAT+1) range regardless of how long the FSM lingers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != TERM_CNT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign term_o = (count_q == TERM_CNT);

endmodule

// File: rtl/braille_rom_sequencer.sv
// braille_rom_sequencer
// Walks a ROM address from FIRST_ADDR to LAST_ADDR, waits READ_LAT cycles at
// each address, captures the ROM word and holds it until the consumer
// acknowledges it. Supports one-shot or looping passes and restart from DONE.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   begin a pass (accepted in IDLE/DONE only)
//   loop       in   at the last word's acknowledge: 1 = wrap, 0 = finish
//   advance    in   consumer acknowledge of data_out
//   q          in   ROM read data
//   address    out  registered ROM address
//   data_out   out  captured ROM word
//   data_valid out  data_out holds an unacknowledged word
//   busy       out  high in WAIT and PRESENT
//   done       out  high in DONE
module braille_rom_sequencer
    import braille_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 5,
    parameter int READ_LAT   = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    input  logic              advance,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    if (READ_LAT < 1) begin : g_bad_lat
        $error("braille_rom_sequencer: READ_LAT must be >= 1");
    end
    if ((FIRST_ADDR < 0) || (FIRST_ADDR > LAST_ADDR) ||
        (LAST_ADDR > (2 ** ADDR_W) - 1)) begin : g_bad_range
        $error("braille_rom_sequencer: need FIRST_ADDR <= LAST_ADDR <= 2^ADDR_W-1");
    end

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              timer_clr;
    logic              timer_en;
    logic              timer_term;

    // Counter restarts whenever a new address is issued: on an accepted start
    // or on an acknowledge that moves to another word.
    assign timer_clr = (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) ||
                       ((state_q == ST_PRESENT) && advance);
    assign timer_en  = (state_q == ST_WAIT);

    seq_wait_timer #(
        .READ_LAT (READ_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .term_o (timer_term)
    );

    // Address following an acknowledge that does not finish the pass. The
    // increment never runs past LAST_ADDR; the only wrap is the explicit loop.
    always_comb begin
        addr_next_d = addr_q;
        if (addr_q != LAST_A) begin
            addr_next_d = addr_q + ADDR_W'(1);
        end else begin
            addr_next_d = FIRST_A;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= FIRST_A;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        addr_q  <= FIRST_A;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer_term) begin
                        data_q  <= q;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (advance) begin
                        valid_q <= 1'b0;
                        if ((addr_q != LAST_A) || loop) begin
                            addr_q  <= addr_next_d;
                            state_q <= ST_WAIT;
                        end else begin
                            // Finish: address stays on LAST_ADDR, word is kept.
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign address    = addr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
